// File: rtl/bj_pkg.sv
// Shared definitions for the multi-seat blackjack table: state codes, result codes
// and the card-rank to point-value mapping.
package bj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DEAL   = 3'd1,
        ST_PLAYER = 3'd2,
        ST_DEALER = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_PUSH = 2'b11;

    // Aces count 1 here; the soft +10 is applied by the hand accumulator.
    function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
        if (rank > 4'd10) begin
            return 4'd10;
        end
        return rank;
    endfunction

endpackage

// File: rtl/bj_hand_acc.sv
// One hand accumulator: keeps the hard total and whether an ace was drawn, and
// derives the best total, soft flag and bust flag from them.
module bj_hand_acc
    import bj_pkg::*;
#(
    parameter int SUM_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             add_i,
    input  logic [3:0]       rank_i,
    output logic [SUM_W-1:0] hard_o,
    output logic             has_ace_o,
    output logic [SUM_W-1:0] best_o,
    output logic             soft_o,
    output logic             bust_o
);

    logic [SUM_W-1:0] hard_q, hard_d;
    logic             ace_q, ace_d;

    always_comb begin
        hard_d = hard_q;
        ace_d  = ace_q;
        if (clear_i) begin
            hard_d = '0;
            ace_d  = 1'b0;
        end else if (add_i) begin
            hard_d = hard_q + SUM_W'(rank_to_value(rank_i));
            ace_d  = ace_q | (rank_i == 4'd1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hard_q <= '0;
            ace_q  <= 1'b0;
        end else begin
            hard_q <= hard_d;
            ace_q  <= ace_d;
        end
    end

    assign hard_o    = hard_q;
    assign has_ace_o = ace_q;
    assign soft_o    = ace_q && (hard_q <= SUM_W'(11));
    assign best_o    = soft_o ? hard_q + SUM_W'(10) : hard_q;
    assign bust_o    = hard_q > SUM_W'(21);

endmodule

// File: rtl/blackjack_table_ctrl.sv
// Multi-seat blackjack round controller: synchronises the buttons, pulls cards from
// the shuffler one at a time, walks the seats and the dealer, and settles results.
module blackjack_table_ctrl
    import bj_pkg::*;
#(
    parameter int N_SEATS      = 2,
    parameter int DEALER_STAND = 17,
    parameter int HIT_SOFT17   = 1,
    parameter int SUM_W        = 5,
    localparam int SEAT_W      = (N_SEATS > 1) ? $clog2(N_SEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     deal,
    input  logic                     hit,
    input  logic                     stand,
    input  logic                     deck_ready,
    input  logic                     card_vld,
    input  logic [3:0]               card_rank,
    output logic                     card_req,
    output logic [2:0]               state,
    output logic [SEAT_W-1:0]        active_seat,
    output logic [N_SEATS*SUM_W-1:0] player_sum,
    output logic [SUM_W-1:0]         dealer_sum,
    output logic [3:0]               dealer_up,
    output logic [N_SEATS*2-1:0]     result
);

    localparam int HANDS      = N_SEATS + 1;
    localparam int DEAL_CARDS = 2 * HANDS;

    logic [2:0] btnRaw;
    logic [2:0] btnEvt;
    logic       dealEvt, hitEvt, standEvt;

    assign btnRaw = {stand, hit, deal};

    // Buttons idle high, so the synchroniser powers up at 1 to avoid a false press.
    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic sync1_q, sync2_q, prev_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                prev_q  <= 1'b1;
            end else begin
                sync1_q <= btnRaw[b];
                sync2_q <= sync1_q;
                prev_q  <= sync2_q;
            end
        end
        assign btnEvt[b] = prev_q & ~sync2_q;
    end

    assign dealEvt  = btnEvt[0];
    assign hitEvt   = btnEvt[1];
    assign standEvt = btnEvt[2];

    state_e                state_q, state_d;
    logic [SEAT_W-1:0]     seat_q, seat_d;
    logic [3:0]            cardCnt_q, cardCnt_d;
    logic                  pending_q, pending_d;
    logic                  showDealer_q, showDealer_d;
    logic [3:0]            dealerUp_q, dealerUp_d;
    logic [N_SEATS*2-1:0]  result_q, result_d;

    logic                  reqCard, handClear, acceptCard;
    logic [3:0]            dealIdx, target;
    logic [HANDS-1:0]      handAdd, handBust, handSoft;
    logic [SUM_W-1:0]      bestSum [HANDS];
    logic [N_SEATS*2-1:0]  settleRes;

    assign acceptCard = card_vld & pending_q;

    always_comb begin
        dealIdx = (cardCnt_q < 4'(HANDS)) ? cardCnt_q : cardCnt_q - 4'(HANDS);
        case (state_q)
            ST_DEAL:   target = dealIdx;
            ST_PLAYER: target = 4'(seat_q);
            default:   target = 4'(N_SEATS);
        endcase
        handAdd = '0;
        for (int h = 0; h < HANDS; h++) begin
            handAdd[h] = acceptCard && (target == 4'(h));
        end
    end

    for (genvar h = 0; h < HANDS; h++) begin : g_hand
        logic [SUM_W-1:0] hardTot;
        logic             aceHeld;
        logic             unusedHand;
        bj_hand_acc #(.SUM_W(SUM_W)) u_hand (
            .clk_i     (clk),
            .rst_ni    (rst),
            .clear_i   (handClear),
            .add_i     (handAdd[h]),
            .rank_i    (card_rank),
            .hard_o    (hardTot),
            .has_ace_o (aceHeld),
            .best_o    (bestSum[h]),
            .soft_o    (handSoft[h]),
            .bust_o    (handBust[h])
        );
        assign unusedHand = ^{hardTot, aceHeld, handSoft[h]};
    end

    logic [SUM_W-1:0] curBest, dealerBest, upValue;
    logic             curBust, dealerBust, dealerDraw, allBust, lastSeat;

    assign curBest    = bestSum[seat_q];
    assign curBust    = handBust[seat_q];
    assign dealerBest = bestSum[N_SEATS];
    assign dealerBust = handBust[N_SEATS];
    assign allBust    = &handBust[N_SEATS-1:0];
    assign lastSeat   = (seat_q == SEAT_W'(N_SEATS - 1));
    assign dealerDraw = (dealerBest < SUM_W'(DEALER_STAND)) ||
                        ((dealerBest == SUM_W'(DEALER_STAND)) && handSoft[N_SEATS] && (HIT_SOFT17 != 0));
    assign upValue    = (dealerUp_q == 4'd1) ? SUM_W'(11) : SUM_W'(rank_to_value(dealerUp_q));

    always_comb begin
        settleRes = '0;
        for (int s = 0; s < N_SEATS; s++) begin
            if (handBust[s]) begin
                settleRes[2*s +: 2] = RES_LOSE;
            end else if (dealerBust || (bestSum[s] > dealerBest)) begin
                settleRes[2*s +: 2] = RES_WIN;
            end else if (bestSum[s] < dealerBest) begin
                settleRes[2*s +: 2] = RES_LOSE;
            end else begin
                settleRes[2*s +: 2] = RES_PUSH;
            end
        end
    end

    // Decisions are only taken with no card in flight, so every card lands in the
    // hand that asked for it and the totals seen here are always up to date.
    always_comb begin
        state_d      = state_q;
        seat_d       = seat_q;
        cardCnt_d    = cardCnt_q;
        pending_d    = pending_q;
        showDealer_d = showDealer_q;
        dealerUp_d   = dealerUp_q;
        result_d     = result_q;
        reqCard      = 1'b0;
        handClear    = 1'b0;
        if (acceptCard) begin
            pending_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (dealEvt && deck_ready) begin
                    handClear    = 1'b1;
                    cardCnt_d    = '0;
                    seat_d       = '0;
                    showDealer_d = 1'b0;
                    dealerUp_d   = '0;
                    result_d     = {(N_SEATS){RES_NONE}};
                    state_d      = ST_DEAL;
                end
            end
            ST_DEAL: begin
                if (acceptCard) begin
                    cardCnt_d = cardCnt_q + 4'd1;
                    if (cardCnt_q == 4'(N_SEATS)) begin
                        dealerUp_d = card_rank;
                    end
                end else if (!pending_q) begin
                    if (cardCnt_q == 4'(DEAL_CARDS)) begin
                        seat_d  = '0;
                        state_d = ST_PLAYER;
                    end else begin
                        reqCard = 1'b1;
                    end
                end
            end
            ST_PLAYER: begin
                if (!pending_q) begin
                    if (curBust || (curBest == SUM_W'(21)) || standEvt) begin
                        if (lastSeat) begin
                            showDealer_d = 1'b1;
                            state_d      = ST_DEALER;
                        end else begin
                            seat_d = seat_q + SEAT_W'(1);
                        end
                    end else if (hitEvt) begin
                        reqCard = 1'b1;
                    end
                end
            end
            ST_DEALER: begin
                if (!pending_q) begin
                    if (!allBust && dealerDraw) begin
                        reqCard = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                result_d = settleRes;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (dealEvt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reqCard) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            seat_q       <= '0;
            cardCnt_q    <= '0;
            pending_q    <= 1'b0;
            showDealer_q <= 1'b0;
            dealerUp_q   <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            seat_q       <= seat_d;
            cardCnt_q    <= cardCnt_d;
            pending_q    <= pending_d;
            showDealer_q <= showDealer_d;
            dealerUp_q   <= dealerUp_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        player_sum = '0;
        for (int s = 0; s < N_SEATS; s++) begin
            player_sum[s*SUM_W +: SUM_W] = bestSum[s];
        end
    end

    assign card_req    = reqCard;
    assign state       = state_q;
    assign active_seat = seat_q;
    assign dealer_up   = dealerUp_q;
    assign dealer_sum  = showDealer_q ? dealerBest : upValue;
    assign result      = result_q;

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// Directed bench for blackjack_table_ctrl: a scripted deck stub answers card requests
// and each round is checked against hand-computed totals and results.
module tb_blackjack_table_ctrl;

    localparam int S_IDLE   = 0;
    localparam int S_DEAL   = 1;
    localparam int S_PLAYER = 2;
    localparam int S_DONE   = 5;

    localparam logic [2:0] BTN_DEAL  = 3'b001;
    localparam logic [2:0] BTN_HIT   = 3'b010;
    localparam logic [2:0] BTN_STAND = 3'b100;

    logic       clk = 1'b0;
    logic       rst, deal, hit, stand, deck_ready, card_vld;
    logic [3:0] card_rank;
    logic       card_req;
    logic [2:0] state;
    logic       active_seat;
    logic [9:0] player_sum;
    logic [4:0] dealer_sum;
    logic [3:0] dealer_up;
    logic [3:0] result;

    int  checkCount = 0;
    int  errorCount = 0;
    int  reqCount   = 0;
    int  base, base2, n;
    bit  stubRespond = 1'b1;
    bit  respondNext = 1'b0;
    int  deckQ[$];

    always #5 clk = ~clk;

    blackjack_table_ctrl #(
        .N_SEATS(2), .DEALER_STAND(17), .HIT_SOFT17(1), .SUM_W(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .deal        (deal),
        .hit         (hit),
        .stand       (stand),
        .deck_ready  (deck_ready),
        .card_vld    (card_vld),
        .card_rank   (card_rank),
        .card_req    (card_req),
        .state       (state),
        .active_seat (active_seat),
        .player_sum  (player_sum),
        .dealer_sum  (dealer_sum),
        .dealer_up   (dealer_up),
        .result      (result)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] btnMask, input int holdCycles);
        @(negedge clk);
        if (btnMask[0]) deal = 1'b0;
        if (btnMask[1]) hit = 1'b0;
        if (btnMask[2]) stand = 1'b0;
        repeat (holdCycles) @(negedge clk);
        deal  = 1'b1;
        hit   = 1'b1;
        stand = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic waitState(input string tag, input int target, input int maxCycles);
        int cnt = 0;
        while (state !== 3'(target) && cnt < maxCycles) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput(tag, 32'(state), 32'(target));
    endtask

    task automatic loadSix(input int a, input int b, input int c, input int d, input int e, input int f);
        deckQ.push_back(a);
        deckQ.push_back(b);
        deckQ.push_back(c);
        deckQ.push_back(d);
        deckQ.push_back(e);
        deckQ.push_back(f);
    endtask

    // Deck stub: a request seen on one falling edge is answered on the next.
    initial begin
        card_vld  = 1'b0;
        card_rank = 4'd0;
        forever begin
            @(negedge clk);
            card_vld = 1'b0;
            if (respondNext) begin
                card_vld = 1'b1;
                if (deckQ.size() > 0) card_rank = 4'(deckQ.pop_front());
                else card_rank = 4'd10;
                respondNext = 1'b0;
            end
            if (card_req === 1'b1) begin
                reqCount++;
                if (stubRespond) respondNext = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; deal = 1'b1; hit = 1'b1; stand = 1'b1; deck_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_state", 32'(state), S_IDLE);
        checkOutput("rst_player_sum", 32'(player_sum), 0);
        checkOutput("rst_dealer_sum", 32'(dealer_sum), 0);
        checkOutput("rst_result", 32'(result), 0);
        checkOutput("rst_card_req", 32'(card_req), 0);
        checkOutput("rst_active_seat", 32'(active_seat), 0);
        checkOutput("rst_dealer_up", 32'(dealer_up), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Round 1: seat0 10,7  seat1 5,6  dealer 9,8; both stand.
        $display("[TB] round 1: basic stand/stand");
        loadSix(10, 5, 9, 7, 6, 8);
        base = reqCount;
        deal = 1'b0;
        n = 0;
        while (state !== 3'(S_DEAL) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("r1_deal_state", 32'(state), S_DEAL);
        checkOutput("r1_first_req", 32'(card_req), 1);
        repeat (4) @(negedge clk);
        deal = 1'b1;
        waitState("r1_player", S_PLAYER, 100);
        checkOutput("r1_player_sum", 32'(player_sum), (11 << 5) | 17);
        checkOutput("r1_dealer_up_only", 32'(dealer_sum), 9);
        checkOutput("r1_dealer_up", 32'(dealer_up), 9);
        checkOutput("r1_seat0", 32'(active_seat), 0);
        applyStimulus(BTN_STAND, 3);
        checkOutput("r1_seat1", 32'(active_seat), 1);
        checkOutput("r1_still_player", 32'(state), S_PLAYER);
        applyStimulus(BTN_STAND, 3);
        waitState("r1_done", S_DONE, 100);
        checkOutput("r1_dealer_sum", 32'(dealer_sum), 17);
        checkOutput("r1_result", 32'(result), 4'b1011);
        checkOutput("r1_reqs", 32'(reqCount - base), 6);

        // Round 2: deck not ready is ignored; seat1 hits to 21 and auto-advances.
        $display("[TB] round 2: deck_ready gate and auto-advance at 21");
        applyStimulus(BTN_DEAL, 3);
        checkOutput("r2_back_idle", 32'(state), S_IDLE);
        deck_ready = 1'b0;
        applyStimulus(BTN_DEAL, 3);
        checkOutput("r2_not_ready", 32'(state), S_IDLE);
        deck_ready = 1'b1;
        loadSix(10, 5, 9, 8, 6, 7);
        deckQ.push_back(13);
        deckQ.push_back(2);
        base = reqCount;
        applyStimulus(BTN_DEAL, 3);
        waitState("r2_player", S_PLAYER, 100);
        applyStimulus(BTN_STAND, 3);
        checkOutput("r2_seat1", 32'(active_seat), 1);
        applyStimulus(BTN_HIT, 3);
        waitState("r2_done", S_DONE, 100);
        checkOutput("r2_player_sum", 32'(player_sum), (21 << 5) | 18);
        checkOutput("r2_dealer_sum", 32'(dealer_sum), 18);
        checkOutput("r2_result", 32'(result), 4'b0111);
        checkOutput("r2_reqs", 32'(reqCount - base), 8);

        // Round 3: held hit, hit+stand together, dealer hits soft 17.
        $display("[TB] round 3: held button, simultaneous press, soft 17");
        applyStimulus(BTN_DEAL, 3);
        loadSix(2, 10, 1, 3, 9, 6);
        deckQ.push_back(4);
        deckQ.push_back(2);
        base = reqCount;
        applyStimulus(BTN_DEAL, 3);
        waitState("r3_player", S_PLAYER, 100);
        checkOutput("r3_dealer_up", 32'(dealer_up), 1);
        base2 = reqCount;
        applyStimulus(BTN_HIT, 20);
        checkOutput("r3_held_hit_reqs", 32'(reqCount - base2), 1);
        checkOutput("r3_seat0_sum", 32'(player_sum[4:0]), 9);
        applyStimulus(BTN_HIT | BTN_STAND, 3);
        checkOutput("r3_simul_seat", 32'(active_seat), 1);
        checkOutput("r3_simul_noreq", 32'(reqCount - base2), 1);
        applyStimulus(BTN_STAND, 3);
        waitState("r3_done", S_DONE, 100);
        checkOutput("r3_dealer_sum", 32'(dealer_sum), 19);
        checkOutput("r3_reqs", 32'(reqCount - base), 8);
        checkOutput("r3_result", 32'(result), 4'b1110);

        // Round 4: both seats bust, dealer must not draw.
        $display("[TB] round 4: all seats bust");
        applyStimulus(BTN_DEAL, 3);
        loadSix(10, 9, 9, 6, 7, 8);
        deckQ.push_back(13);
        deckQ.push_back(12);
        base = reqCount;
        applyStimulus(BTN_DEAL, 3);
        waitState("r4_player", S_PLAYER, 100);
        checkOutput("r4_dealer_up_only", 32'(dealer_sum), 9);
        applyStimulus(BTN_HIT, 3);
        checkOutput("r4_seat1", 32'(active_seat), 1);
        applyStimulus(BTN_HIT, 3);
        waitState("r4_done", S_DONE, 100);
        checkOutput("r4_player_sum", 32'(player_sum), (26 << 5) | 26);
        checkOutput("r4_dealer_sum", 32'(dealer_sum), 17);
        checkOutput("r4_result", 32'(result), 4'b1010);
        checkOutput("r4_reqs", 32'(reqCount - base), 8);

        // Round 5: reset with a card pending, stale strobe, then a clean round.
        $display("[TB] round 5: reset mid-round");
        applyStimulus(BTN_DEAL, 3);
        loadSix(2, 3, 4, 5, 6, 7);
        applyStimulus(BTN_DEAL, 3);
        waitState("r5_player", S_PLAYER, 100);
        stubRespond = 1'b0;
        base = reqCount;
        applyStimulus(BTN_HIT, 3);
        checkOutput("r5_req_pending", 32'(reqCount - base), 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("r5_rst_state", 32'(state), S_IDLE);
        checkOutput("r5_rst_player_sum", 32'(player_sum), 0);
        checkOutput("r5_rst_dealer_sum", 32'(dealer_sum), 0);
        checkOutput("r5_rst_card_req", 32'(card_req), 0);
        rst = 1'b1;
        stubRespond = 1'b1;
        deckQ.delete();
        deckQ.push_back(10);
        respondNext = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("r5_late_vld_sum", 32'(player_sum), 0);
        checkOutput("r5_late_vld_state", 32'(state), S_IDLE);
        loadSix(10, 10, 10, 9, 8, 7);
        applyStimulus(BTN_DEAL, 3);
        waitState("r5_player", S_PLAYER, 100);
        checkOutput("r5_player_sum", 32'(player_sum), (18 << 5) | 19);
        applyStimulus(BTN_STAND, 3);
        applyStimulus(BTN_STAND, 3);
        waitState("r5_done", S_DONE, 100);
        checkOutput("r5_result", 32'(result), 4'b0101);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
